// File: rtl/aging_fifo_packer.sv
// Drains the show-ahead byte FIFO and packs bytes little-endian into bus words.
// Partial words go out on flush or after an idle timeout.
module aging_fifo_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 16
) (
  input  logic                        clock,
  input  logic                        sclr,
  input  logic                        fifo_empty,
  input  logic [7:0]                  fifo_q,
  output logic                        fifo_rdreq,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [2:0]                  out_bytes,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_idx, w_idx;
  logic [W-1:0]     r_lanes, w_lanes;
  logic [2:0]       r_bytes, w_bytes;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_pend, w_pend;
  logic [IW-1:0]    r_idle, w_idle;

  logic w_pop;
  logic w_last;
  logic w_stall;
  logic w_tmo;

  assign w_pop   = sclr && (r_state == S_FILL) && !fifo_empty;
  assign w_last  = (r_idx == 3'(BYTES_PER_WORD - 1));
  assign w_stall = (r_state == S_FILL) && fifo_empty && (r_idx != 3'd0);
  assign w_tmo   = (TIMEOUT > 0) && w_stall
                && (r_idle == IW'(TIMEOUT - 1));

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_lanes = r_lanes;
    w_bytes = r_bytes;
    w_cnt   = r_cnt;
    w_pend  = r_pend | flush;
    w_idle  = r_idle;
    unique case (r_state)
      S_FILL: begin
        if (w_pop) begin
          for (int l = 0; l < BYTES_PER_WORD; l++) begin
            if (r_idx == 3'(l)) w_lanes[l*8 +: 8] = fifo_q;
          end
          w_idx  = r_idx + 3'd1;
          w_idle = '0;
          if (w_last) begin
            w_state = S_HOLD;
            w_bytes = 3'(BYTES_PER_WORD);
          end
        end else if (r_pend) begin
          // FIFO is drained here; a concurrent flush is absorbed
          w_pend = 1'b0;
          w_idle = '0;
          if (r_idx != 3'd0) begin
            w_state = S_HOLD;
            w_bytes = r_idx;
          end
        end else if (w_tmo) begin
          w_state = S_HOLD;
          w_bytes = r_idx;
          w_idle  = '0;
        end else if (w_stall && TIMEOUT > 0) begin
          w_idle = r_idle + IW'(1);
        end
      end
      S_HOLD: begin
        w_idle = '0;
        if (out_ready) begin
          w_cnt   = r_cnt + CNT_W'(1);
          w_lanes = '0;
          w_idx   = 3'd0;
          w_bytes = 3'd0;
          w_state = S_FILL;
        end
      end
      default: w_state = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sclr) begin
      r_state <= S_FILL;
      r_idx   <= 3'd0;
      r_lanes <= '0;
      r_bytes <= 3'd0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_lanes <= w_lanes;
      r_bytes <= w_bytes;
      r_cnt   <= w_cnt;
      r_pend  <= w_pend;
      r_idle  <= w_idle;
    end
  end

  assign fifo_rdreq = w_pop;
  assign out_valid  = (r_state == S_HOLD);
  assign out_data   = r_lanes;
  assign out_bytes  = r_bytes;
  assign word_cnt   = r_cnt;

endmodule

// File: tb/tb_aging_fifo_packer.sv
// Scoreboard bench for aging_fifo_packer: directed byte streams,
// expected words queued at issue time, monitor compares on handshake.
module tb_aging_fifo_packer;

  logic        clock;
  logic        sclr;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;

  aging_fifo_packer #(
    .BYTES_PER_WORD(4),
    .TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .sclr(sclr),
    .fifo_empty(fifo_empty),
    .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_bytes(out_bytes),
    .word_cnt(word_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // show-ahead FIFO model
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);
  assign fifo_q     = mem[rp[5:0]];
  always @(posedge clock) begin
    if (fifo_rdreq && wp != rp) rp <= rp + 1;
  end

  logic [34:0] exp_q [$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[5:0]] = b;
    wp++;
  endtask

  task automatic expect_word(input logic [2:0] b,
                             input logic [31:0] d);
    exp_q.push_back({b, d});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && fifo_empty && !out_valid) return;
      tick(1);
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // monitor
  logic [31:0] prev_d;
  logic [2:0]  prev_b;
  bit          prev_hold = 0;
  logic [34:0] e;
  always @(negedge clock) begin
    if (!sclr) begin
      prev_hold = 0;
    end else begin
      if (out_valid) begin
        chk("rdreq_in_hold", 64'(fifo_rdreq), 64'd0);
        if (prev_hold)
          chk("hold_stable", {29'd0, out_bytes, out_data},
              {29'd0, prev_b, prev_d});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {29'd0, out_bytes, out_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word", {29'd0, out_bytes, out_data}, {29'd0, e});
        end
        prev_hold = 0;
      end else begin
        prev_hold = out_valid;
        prev_d    = out_data;
        prev_b    = out_bytes;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sclr      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_bytes", 64'(out_bytes), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    sclr = 1'b1;
    tick(1);

    // full word, consecutive pops
    expect_word(3'd4, 32'h44332211);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(4);
    chk("t1_valid_latency", 64'(out_valid), 64'd1);
    tick(1);
    chk("t1_cnt", 64'(word_cnt), 64'd1);
    drain(50);

    // back-pressure with FIFO non-empty during HOLD
    out_ready = 1'b0;
    expect_word(3'd4, 32'hA4A3A2A1);
    expect_word(3'd4, 32'hB4B3B2B1);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    tick(4);
    chk("t2_valid", 64'(out_valid), 64'd1);
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    tick(10);
    chk("t2_still_valid", 64'(out_valid), 64'd1);
    chk("t2_cnt_held", 64'(word_cnt), 64'd1);
    out_ready = 1'b1;
    tick(1);
    chk("t2_cnt_once", 64'(word_cnt), 64'd2);
    drain(50);
    chk("t2_cnt_end", 64'(word_cnt), 64'd3);

    // six bytes then flush
    expect_word(3'd4, 32'h04030201);
    expect_word(3'd2, 32'h00000605);
    for (int i = 1; i <= 6; i++) push(8'(i));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    drain(50);
    chk("t3_cnt", 64'(word_cnt), 64'd5);

    // flush with nothing packed: no word, pending flag drops
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    chk("t4_no_valid", 64'(out_valid), 64'd0);
    tick(1);
    expect_word(3'd1, 32'h00000077);
    push(8'h77);
    tick(2);
    chk("t4_pend_cleared_a", 64'(out_valid), 64'd0);
    tick(1);
    chk("t4_pend_cleared_b", 64'(out_valid), 64'd0);
    drain(50);
    chk("t4_cnt", 64'(word_cnt), 64'd6);

    // idle timeout with a single byte
    out_ready = 1'b0;
    expect_word(3'd1, 32'h000000AB);
    push(8'hAB);
    tick(1);
    tick(7);
    chk("t5_not_yet", 64'(out_valid), 64'd0);
    tick(1);
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_data", 64'(out_data), 64'h000000AB);
    chk("t5_bytes", 64'(out_bytes), 64'd1);
    out_ready = 1'b1;
    drain(50);

    // reset mid-word
    push(8'hC1); push(8'hC2);
    tick(2);
    sclr = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    #1;
    chk("t6_rdreq_in_rst", 64'(fifo_rdreq), 64'd0);
    tick(1);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_bytes", 64'(out_bytes), 64'd0);
    chk("t6_cnt", 64'(word_cnt), 64'd0);
    expect_word(3'd4, 32'hD4D3D2D1);
    sclr = 1'b1;
    drain(50);
    chk("t6_cnt_end", 64'(word_cnt), 64'd1);

    tick(3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
